wl_mont_reduce_seq: RTL and testbench

// Iterative word-level Montgomery reduction sequencer for NTT-friendly moduli q = q_hat*2^W + 1.
// - Accepts a wide product T and retires one W-bit word per cycle: T <- (T>>W) + q_hat*m + c.
// - Returns R = T * 2^(-LOGQ) mod q.
// - Serves as the control/accumulate side of the multiply-and-add (A*B+C+D) datapath.
// - Sits between the modular multiplier front-end and the NTT butterfly result path.

---
 rtl/wl_mont_reduce_seq.sv | 166 ++++++++++++++++
 tb/tb_wl_mont_reduce_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wl_mont_reduce_seq.sv
// Iterative word-level Montgomery reduction for moduli q = q_hat*2^W + 1.
// Each RED cycle retires the low W-bit word of T:
//   T <- (T >> W) + q_hat*m + c,  m = -T[W-1:0] mod 2^W,  c = (T[W-1:0] != 0)
// After ITER = LOGQ/W iterations, R = T * 2^(-LOGQ) mod q, with T < 2q.
//
// Optional feature macro: WL_MONT_FINAL_SUB_EN
//   defined   : one SUB cycle reduces T into [0, q); latency ITER+2
//   undefined : out_r = T truncated to LOGQ bits (in [0, 2q)); latency ITER+1
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid
//   in_ready   operand accepted when high (IDLE only)
//   in_t       2*LOGQ-bit product to reduce (in_t < q*2^LOGQ)
//   in_q       LOGQ-bit modulus, low W bits must be 1
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts result
//   out_r      LOGQ-bit reduced result
//   busy       high in any state other than IDLE
module wl_mont_reduce_seq #(
  parameter int unsigned LOGQ = 64,
  parameter int unsigned W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*LOGQ-1:0] in_t,
  input  logic [LOGQ-1:0]   in_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOGQ-1:0]   out_r,
  output logic              busy
);

  localparam int unsigned ITER = LOGQ / W;
  localparam int unsigned TW   = 2 * LOGQ + 1;
  localparam int unsigned QHW  = LOGQ - W;
  localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CntLast = CW'(ITER - 1);

  typedef enum logic [1:0] {StIdle, StRed, StSub, StDone} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   t_q;
  logic [QHW-1:0]  qh_q;
  logic [CW-1:0]   cnt_q;
  logic            out_valid_q;
  logic [LOGQ-1:0] out_r_q;
  logic            accept;

  // One reduction step. The product is formed at full LOGQ width so nothing
  // is lost before it joins the shifted accumulator.
  logic [W-1:0]    tl, m;
  logic            c;
  logic [LOGQ-1:0] prod;
  logic [TW-1:0]   t_red;

  always_comb begin
    tl    = t_q[W-1:0];
    m     = '0 - tl;
    c     = |tl;
    prod  = {{W{1'b0}}, qh_q} * {{QHW{1'b0}}, m};
    t_red = (t_q >> W) + {{(TW-LOGQ){1'b0}}, prod} + {{(TW-1){1'b0}}, c};
  end

`ifdef WL_MONT_FINAL_SUB_EN
  logic [LOGQ-1:0] q_q;
  logic [TW-1:0]   q_ext, t_sub;

  always_comb begin
    q_ext = {{(TW-LOGQ){1'b0}}, q_q};
    t_sub = (t_q >= q_ext) ? (t_q - q_ext) : t_q;
  end
`else
  // Only q_hat is needed when no final subtraction is performed.
  logic unused_q_lsb;
  assign unused_q_lsb = ^in_q[W-1:0];
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StRed;
      StRed: begin
        if (cnt_q == CntLast) begin
`ifdef WL_MONT_FINAL_SUB_EN
          state_d = StSub;
`else
          state_d = StDone;
`endif
        end
      end
      StSub:  state_d = StDone;
      StDone: if (out_valid_q && out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    accept    = in_valid && (state_q == StIdle);
    out_valid = out_valid_q;
    out_r     = out_r_q;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q         <= '0;
      qh_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
`ifdef WL_MONT_FINAL_SUB_EN
      q_q         <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            t_q   <= {1'b0, in_t};
            qh_q  <= in_q[LOGQ-1:W];
            cnt_q <= '0;
`ifdef WL_MONT_FINAL_SUB_EN
            q_q   <= in_q;
`endif
          end
        end
        StRed: begin
          t_q   <= t_red;
          cnt_q <= cnt_q + CW'(1);
        end
        StSub: begin
`ifdef WL_MONT_FINAL_SUB_EN
          t_q <= t_sub;
`endif
        end
        StDone: begin
          // First DONE cycle registers the result; it then holds until taken.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_r_q     <= t_q[LOGQ-1:0];
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wl_mont_reduce_seq.sv
module tb_wl_mont_reduce_seq;

  localparam int unsigned LOGQ = 32;
  localparam int unsigned W    = 16;
  localparam logic [31:0] Q1   = 32'hFFF1_0001;
  localparam logic [31:0] Q2   = 32'h7FF1_0001;
`ifdef WL_MONT_FINAL_SUB_EN
  localparam int          LAT  = 4;
  localparam logic [31:0] EXP3 = 32'h0;
`else
  localparam int          LAT  = 3;
  localparam logic [31:0] EXP3 = Q1;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_t;
  logic [31:0] in_q;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic        busy;

  wl_mont_reduce_seq #(
    .LOGQ(LOGQ),
    .W   (W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_t     (in_t),
    .in_q     (in_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_r    (out_r),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] t;
    logic [31:0] q;
    logic [31:0] r;
  } item_t;

  item_t exp_q[$];
  item_t cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Full-width Montgomery reduction: M = -T*q^-1 mod 2^32, R = (T + M*q) / 2^32.
  function automatic logic [31:0] model(input logic [63:0] t, input logic [31:0] q);
    logic [31:0]  qinv;
    logic [31:0]  mm;
    logic [127:0] s;
    qinv = 32'd1;
    for (int i = 0; i < 5; i++) qinv = qinv * (32'd2 - q * qinv);
    mm = 32'd0 - t[31:0] * qinv;
    s  = ({64'd0, t} + 128'(mm) * 128'(q)) >> 32;
`ifdef WL_MONT_FINAL_SUB_EN
    if (s >= 128'(q)) s = s - 128'(q);
`endif
    return s[31:0];
  endfunction

  // Compare process: every cycle a result is presented.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1, expected 0");
      end else begin
        logic [127:0] lhs, rhs;
        logic         do_prop;
        logic [63:0]  bound;
        cur = exp_q[0];
        check("out_r_model", 64'(out_r), 64'(cur.r));
`ifdef WL_MONT_FINAL_SUB_EN
        do_prop = 1'b1;
        bound   = 64'(cur.q);
`else
        do_prop = (cur.q < 32'h8000_0000);
        bound   = 64'(cur.q) * 64'd2;
`endif
        if (do_prop) begin
          lhs = ({96'd0, out_r} << 32) % {96'd0, cur.q};
          rhs = {64'd0, cur.t} % {96'd0, cur.q};
          check("congruence", lhs[63:0], rhs[63:0]);
          check("range", 64'(64'(out_r) < bound), 64'd1);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [63:0] t, input logic [31:0] q, input bit push,
                      output int waited);
    item_t it;
    in_valid = 1'b1;
    in_t     = t;
    in_q     = q;
    waited   = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 50);
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1");
    end else if (push) begin
      it.t = t;
      it.q = q;
      it.r = model(t, q);
      exp_q.push_back(it);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble inputs: the DUT must work from its sampled copies.
    in_t     = {$urandom, $urandom};
    in_q     = $urandom;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_t(input logic [31:0] q);
    logic [31:0] hi;
    hi = $urandom % q;
    return {hi, 32'($urandom)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          w;
    int          cyc;
    logic [31:0] held;
    logic [63:0] tb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_t      = '0;
    in_q      = '0;

    #2;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_r", 64'(out_r), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pin the model to hand-worked values.
    check("model_zero", 64'(model(64'd0, Q1)), 64'd0);
    check("model_pow2", 64'(model(64'h1_0000_0000, Q1)), 64'd1);
    check("model_q", 64'(model(64'(Q1), Q1)), 64'(EXP3));
    check("model_q2_pow32", 64'(model(64'h1_0000_0000, Q2)), 64'd1);

    // 1: zero operand, latency
    send(64'd0, Q1, 1'b1, w);
    check("busy_after_accept", 64'(busy), 64'd1);
    check("in_ready_after_accept", 64'(in_ready), 64'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    check("latency", 64'(cyc), 64'(LAT));
    drain();

    // 2: 2^32 -> 1
    send(64'h1_0000_0000, Q1, 1'b1, w);
    drain();
    // 3: T = q
    send(64'(Q1), Q1, 1'b1, w);
    drain();
    // Largest legal operand for each modulus
    send({Q1 - 32'd1, 32'hFFFF_FFFF}, Q1, 1'b1, w);
    drain();
    send({Q2 - 32'd1, 32'hFFFF_FFFF}, Q2, 1'b1, w);
    drain();

    // 4: random operands
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] q;
      q = (i % 2 == 0) ? Q1 : Q2;
      send(rand_t(q), q, 1'b1, w);
      drain();
    end

    // 5: backpressure in DONE with a pending operand
    out_ready = 1'b0;
    send(rand_t(Q2), Q2, 1'b1, w);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    check("bp_latency", 64'(cyc), 64'(LAT));
    held     = out_r;
    tb       = rand_t(Q2);
    in_valid = 1'b1;
    in_t     = tb;
    in_q     = Q2;
    repeat (5) begin
      @(negedge clk);
      check("hold_out_r", 64'(out_r), 64'(held));
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(tb, Q2, 1'b1, w);
    check("reaccept_delay", 64'(w), 64'd2);
    drain();

    // 6: reset during the first iteration
    send(rand_t(Q1), Q1, 1'b0, w);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check("abort_edge_out_valid", 64'(out_valid), 64'd0);
    check("abort_edge_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(64'h1_0000_0000, Q1, 1'b1, w);
    drain();
    send(rand_t(Q1), Q1, 1'b1, w);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
